multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle RISC-V control FSM. It is the sequential successor of the single-cycle main decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Adds a memory ready-handshake with a wait-state timeout and a sticky trap for illegal opcodes or memory timeout.
- Sits between the datapath (IR opcode, ALU zero flag) and the unified instruction/data memory port.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles a memory state waits for mem_ready; 0 disables the timeout.
- CNT_W, 5: wait counter width; requires 2^CNT_W > TIMEOUT_CYCLES.
- STATE_W, 4: state register width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write enable, valid with mem_req
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_update  out  1  PC write enable, including a taken branch
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct
- result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
- reg_write  out  1  register file write
- trap  out  1  sticky fault
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, wait counter = 0, trap = 0, trap_cause = 00. All outputs are 0.
- Outputs are Moore-decoded from state. Exceptions: ir_write and pc_update also depend on mem_ready (FETCH) or zero (BEQ). Any output not listed for a state is 0.
- IDLE: no outputs asserted. Always goes to FETCH next cycle.
- FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - When mem_ready = 1: ir_write = 1, pc_update = 1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - anything else -> TRAP with cause 01
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Load goes to MEMREAD, store goes to MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. When mem_ready = 1, go to MEMWB.
- MEMWB: result_src = 01, reg_write = 1, then FETCH.
- MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1. When mem_ready = 1, go to FETCH.
- EXECUTER: alu_src_a = 10, alu_src_b = 00, alu_op = 10, then ALUWB.
- EXECUTEI: alu_src_a = 10, alu_src_b = 01, alu_op = 11, then ALUWB.
- ALUWB: result_src = 00, reg_write = 1, then FETCH.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, pc_update = zero. Then FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle in those states while mem_ready = 0.
  - If the counter equals TIMEOUT_CYCLES-1 and mem_ready = 0, go to TRAP with cause 10.
  - mem_ready = 1 in that same cycle wins: normal transition, no trap.
  - TIMEOUT_CYCLES = 0 means wait indefinitely.
- TRAP: all control outputs 0, trap = 1, trap_cause held. Exit only via reset.
- Reset mid-operation, including during an outstanding memory request: mem_req drops immediately (asynchronous). No write or commit is issued.

Optional Feature:
- Macro MC_CTRL_JAL_EN.
- Defined: opcode 1101111 in DECODE goes to JAL state.
  - JAL outputs: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1. PC takes the target held in ALUOut; the ALU computes oldPC+4.
  - JAL then goes to ALUWB, which writes the link value.
- Undefined: JAL state does not exist; 1101111 traps with cause 01.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - ALUOp, src-select and result-select encodings
  - trap cause codes
- One sub-module, mc_wait_timer: wait counter plus timeout compare, parametrised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Reset release, mem_ready tied to 1, opcode 0110011 -> states IDLE, FETCH, DECODE, EXECUTER, ALUWB, FETCH. reg_write = 1 only in ALUWB; alu_op = 10 in EXECUTER.
- Load (0000011), mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req = 1, adr_src = 1. MEMWB then asserts reg_write = 1, result_src = 01.
- BEQ with zero = 1, then zero = 0 -> pc_update = 1 and then 0 in the BEQ cycle. Both return to FETCH.
- Opcode 1111111 -> TRAP, trap = 1, trap_cause = 01. Outputs stay 0 for 20 cycles; rst_n pulse returns to IDLE with trap = 0.
- TIMEOUT_CYCLES = 4, mem_ready stuck low in FETCH -> TRAP after 4 FETCH cycles, cause 10. Variant with mem_ready = 1 on the 4th cycle -> proceeds to DECODE, no trap.
- MC_CTRL_JAL_EN defined, opcode 1101111 -> DECODE, JAL (pc_update = 1), ALUWB (reg_write = 1). Build without the macro -> trap cause 01.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM.
// The JAL state exists only when MC_CTRL_JAL_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTER = 4'd7,
        ST_EXECUTEI = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BEQ      = 4'd10,
`ifdef MC_CTRL_JAL_EN
        ST_JAL      = 4'd11,
`endif
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // States that hold a memory request open and are subject to the timeout.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter with timeout compare; TIMEOUT_CYCLES = 0 never times out.
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    logic [CNT_W-1:0] count_reg;

    // Any cycle that is not a stalled wait cycle leaves the counter at zero,
    // so every entry into a wait state starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (active && !mem_ready) begin
            count_reg <= count_reg + 1'b1;
        end else begin
            count_reg <= '0;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : gen_no_timeout
            assign timeout = 1'b0;
        end else begin : gen_timeout
            assign timeout = active && !mem_ready
                             && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with memory handshake timeout and sticky trap.
// Optional JAL support is enabled by defining MC_CTRL_JAL_EN.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5,
    parameter int STATE_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_update,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
    output logic               reg_write,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [STATE_W-1:0] state
);

    state_t     state_reg, state_next;
    logic [1:0] trap_cause_reg, trap_cause_next;
    logic       timeout;

    mc_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (is_wait_state(state_reg)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            trap_cause_reg <= TRAP_NONE;
        end else begin
            state_reg      <= state_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        adr_src         = ADR_PC;
        ir_write        = 1'b0;
        pc_update       = 1'b0;
        alu_src_a       = SRCA_PC;
        alu_src_b       = SRCB_RS2;
        alu_op          = ALUOP_ADD;
        result_src      = RES_ALUOUT;
        reg_write       = 1'b0;
        trap            = 1'b0;
        trap_cause      = TRAP_NONE;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req    = 1'b1;
                adr_src    = ADR_PC;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU;
                // A ready in the timeout cycle still completes the fetch.
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_update  = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                    OP_R:              state_next = ST_EXECUTER;
                    OP_I:              state_next = ST_EXECUTEI;
                    OP_BRANCH:         state_next = ST_BEQ;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:            state_next = ST_JAL;
`endif
                    default: begin
                        state_next      = ST_TRAP;
                        trap_cause_next = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                state_next = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) begin
                    state_next = ST_MEMWB;
                end else if (timeout) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TRAP_TIMEOUT;
                end
            end
            ST_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                end else if (timeout) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TRAP_TIMEOUT;
                end
            end
            ST_EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_RFUNCT;
                state_next = ST_ALUWB;
            end
            ST_EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_IFUNCT;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_BRANCH;
                result_src = RES_ALUOUT;
                pc_update  = zero;
                state_next = ST_FETCH;
            end
`ifdef MC_CTRL_JAL_EN
            // PC loads the target already in ALUOut; the ALU forms oldPC+4 for the link.
            ST_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                state_next = ST_ALUWB;
            end
`endif
            ST_TRAP: begin
                trap       = 1'b1;
                trap_cause = trap_cause_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign state = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (TIMEOUT_CYCLES = 4).
// Honours MC_CTRL_JAL_EN to choose the expected JAL behaviour.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_update, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
    logic [3:0] state;
    logic [16:0] ctl;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (5),
        .STATE_W        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .reg_write  (reg_write),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    always #5 clk = ~clk;

    // mem_req, mem_we, adr_src, ir_write, pc_update, a, b, aluop, res, reg_write, trap, cause
    assign ctl = {mem_req, mem_we, adr_src, ir_write, pc_update, alu_src_a, alu_src_b,
                  alu_op, result_src, reg_write, trap, trap_cause};

    localparam logic [16:0] W_IDLE       = 17'd0;
    localparam logic [16:0] W_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_MEMREAD    = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,1'b1,1'b0,2'b00};
    localparam logic [16:0] W_MEMWRITE   = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_EXER       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_EXEI       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b11,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,2'b00};
    localparam logic [16:0] W_BEQ_T      = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b01,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_BEQ_NT     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_JAL        = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b10,2'b00,2'b00,1'b0,1'b0,2'b00};
    localparam logic [16:0] W_TRAP_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,2'b01};
    localparam logic [16:0] W_TRAP_TMO   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,2'b10};

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk); #1;
        n_vec++; if (state !== ST_IDLE || ctl !== W_IDLE) begin n_err++; $display("FAIL reset_hold: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_IDLE, W_IDLE); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        do_reset(); opcode = OP_R; mem_ready = 1'b1; #1;
        n_vec++; if (state !== ST_IDLE || ctl !== W_IDLE) begin n_err++; $display("FAIL rtype_idle: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_IDLE, W_IDLE); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_RDY) begin n_err++; $display("FAIL rtype_fetch: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_FETCH, W_FETCH_RDY); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_DECODE || ctl !== W_DECODE) begin n_err++; $display("FAIL rtype_decode: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_DECODE, W_DECODE); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_EXECUTER || ctl !== W_EXER) begin n_err++; $display("FAIL rtype_exec: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_EXECUTER, W_EXER); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_ALUWB || ctl !== W_ALUWB) begin n_err++; $display("FAIL rtype_aluwb: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_ALUWB, W_ALUWB); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_RDY) begin n_err++; $display("FAIL rtype_refetch: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_FETCH, W_FETCH_RDY); end
    endtask

    task automatic test_itype;
        do_reset(); opcode = OP_I; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (state !== ST_EXECUTEI || ctl !== W_EXEI) begin n_err++; $display("FAIL itype_exec: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_EXECUTEI, W_EXEI); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_ALUWB || ctl !== W_ALUWB) begin n_err++; $display("FAIL itype_aluwb: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_ALUWB, W_ALUWB); end
    endtask

    task automatic test_load_wait;
        do_reset(); opcode = OP_LOAD; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (state !== ST_MEMADR || ctl !== W_MEMADR) begin n_err++; $display("FAIL load_memadr: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_MEMADR, W_MEMADR); end
        @(negedge clk);
        // Ready arrives in the fourth cycle, which is also the timeout cycle.
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            n_vec++; if (state !== ST_MEMREAD || ctl !== W_MEMREAD) begin n_err++; $display("FAIL load_memread%0d: state=%0d ctl=%h, want state=%0d ctl=%h", i, state, ctl, ST_MEMREAD, W_MEMREAD); end
            @(negedge clk);
        end
        #1;
        n_vec++; if (state !== ST_MEMWB || ctl !== W_MEMWB) begin n_err++; $display("FAIL load_memwb: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_MEMWB, W_MEMWB); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_RDY) begin n_err++; $display("FAIL load_refetch: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_FETCH, W_FETCH_RDY); end
    endtask

    task automatic test_beq;
        do_reset(); opcode = OP_BRANCH; mem_ready = 1'b1; zero = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (state !== ST_BEQ || ctl !== W_BEQ_T) begin n_err++; $display("FAIL beq_taken: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_BEQ, W_BEQ_T); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_RDY) begin n_err++; $display("FAIL beq_taken_ret: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_FETCH, W_FETCH_RDY); end
        @(negedge clk); zero = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (state !== ST_BEQ || ctl !== W_BEQ_NT) begin n_err++; $display("FAIL beq_not_taken: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_BEQ, W_BEQ_NT); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_RDY) begin n_err++; $display("FAIL beq_nt_ret: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_FETCH, W_FETCH_RDY); end
    endtask

    task automatic test_illegal;
        do_reset(); opcode = 7'b1111111; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        // Inputs wiggle while trapped; nothing may leak out.
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; zero = i[1]; opcode = (i[2]) ? OP_R : 7'b1111111; #1;
            n_vec++; if (state !== ST_TRAP || ctl !== W_TRAP_ILL) begin n_err++; $display("FAIL illegal_trap%0d: state=%0d ctl=%h, want state=%0d ctl=%h", i, state, ctl, ST_TRAP, W_TRAP_ILL); end
            @(negedge clk);
        end
        rst_n = 1'b0; #1;
        n_vec++; if (state !== ST_IDLE || ctl !== W_IDLE) begin n_err++; $display("FAIL illegal_reset: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_IDLE, W_IDLE); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_timeout;
        do_reset(); opcode = OP_R; mem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_WAIT) begin n_err++; $display("FAIL tmo_fetch%0d: state=%0d ctl=%h, want state=%0d ctl=%h", i, state, ctl, ST_FETCH, W_FETCH_WAIT); end
            @(negedge clk);
        end
        #1;
        n_vec++; if (state !== ST_TRAP || ctl !== W_TRAP_TMO) begin n_err++; $display("FAIL tmo_trap: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_TRAP, W_TRAP_TMO); end
        mem_ready = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (state !== ST_TRAP || ctl !== W_TRAP_TMO) begin n_err++; $display("FAIL tmo_sticky: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_TRAP, W_TRAP_TMO); end
        // Variant: ready in the last allowed cycle wins over the timeout.
        do_reset(); mem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) @(negedge clk);
        mem_ready = 1'b1; #1;
        n_vec++; if (state !== ST_FETCH || ctl !== W_FETCH_RDY) begin n_err++; $display("FAIL tmo_late_ready: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_FETCH, W_FETCH_RDY); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_DECODE || ctl !== W_DECODE) begin n_err++; $display("FAIL tmo_late_decode: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_DECODE, W_DECODE); end
    endtask

    task automatic test_store_reset;
        do_reset(); opcode = OP_STORE; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (state !== ST_MEMWRITE || ctl !== W_MEMWRITE) begin n_err++; $display("FAIL store_memwrite: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_MEMWRITE, W_MEMWRITE); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (state !== ST_IDLE || ctl !== W_IDLE) begin n_err++; $display("FAIL store_async_reset: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_IDLE, W_IDLE); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_jal;
        do_reset(); opcode = OP_JAL; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
`ifdef MC_CTRL_JAL_EN
        n_vec++; if (state !== ST_JAL || ctl !== W_JAL) begin n_err++; $display("FAIL jal_state: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_JAL, W_JAL); end
        @(negedge clk); #1;
        n_vec++; if (state !== ST_ALUWB || ctl !== W_ALUWB) begin n_err++; $display("FAIL jal_aluwb: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_ALUWB, W_ALUWB); end
`else
        n_vec++; if (state !== ST_TRAP || ctl !== W_TRAP_ILL) begin n_err++; $display("FAIL jal_disabled: state=%0d ctl=%h, want state=%0d ctl=%h", state, ctl, ST_TRAP, W_TRAP_ILL); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_store_reset();
        test_jal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
